// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: handshake/control bundle between the instruction-side
// environment (memory, IR, multiplier, datapath) and the sequencer.
//   START/STOP      - run control into the sequencer
//   MEM_READY/MEM_RD- instruction memory handshake
//   OP_CODE/FUNCT   - IR fields classified in DECODE
//   MUL_DONE/START  - multiplier handshake
//   IR_LD/PC_INC/HAB- datapath strobes and control-decoder enable
//   BUSY/ILLEGAL/INSTR_CNT - status
// Modports: master = environment side, slave = sequencer side.
interface cpu_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             START;
    logic             STOP;
    logic             MEM_READY;
    logic [5:0]       OP_CODE;
    logic [5:0]       FUNCT;
    logic             MUL_DONE;
    logic             MEM_RD;
    logic             IR_LD;
    logic             PC_INC;
    logic             HAB;
    logic             MUL_START;
    logic             BUSY;
    logic             ILLEGAL;
    logic [CNT_W-1:0] INSTR_CNT;

    modport master (
        output START, STOP, MEM_READY, OP_CODE, FUNCT, MUL_DONE,
        input  MEM_RD, IR_LD, PC_INC, HAB, MUL_START, BUSY, ILLEGAL, INSTR_CNT
    );

    modport slave (
        input  START, STOP, MEM_READY, OP_CODE, FUNCT, MUL_DONE,
        output MEM_RD, IR_LD, PC_INC, HAB, MUL_START, BUSY, ILLEGAL, INSTR_CNT
    );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer.
// Walks each instruction through FETCH -> DECODE -> EXEC (or MUL_WAIT -> WB)
// and gates the control decoder via HAB so control bits only reach the
// datapath in EXEC/WB. Illegal encodings and multiplier timeouts park the
// machine in TRAP until reset.
// Ports:
//   CLK   - rising-edge clock
//   RST_N - synchronous active-low reset
//   bus   - cpu_sequencer_if.slave (run control, memory/IR/multiplier
//           handshakes, datapath strobes, status)
module cpu_sequencer #(
    parameter int MUL_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    cpu_sequencer_if.slave  bus
);
    localparam int MW_W = $clog2(MUL_TIMEOUT + 1);
    localparam logic [MW_W-1:0] MW_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MUL_WAIT, S_WB, S_TRAP
    } state_e;

    typedef enum logic [1:0] {C_ALU, C_MUL, C_NOP, C_BAD} cls_e;

    state_e           state_q, state_d;
    logic [MW_W-1:0]  mw_cnt_q, mw_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q;
    logic             mem_rd_q, hab_q, busy_q, illegal_q;
    logic             ir_ld, pc_inc, mul_start, retire;
    cls_e             cls;

    // Instruction class from the IR fields; only meaningful in DECODE.
    always_comb begin
        cls = C_BAD;
        case (bus.OP_CODE)
            6'b000000: begin
                case (bus.FUNCT)
                    6'b100000, 6'b100010: cls = C_ALU;
                    6'b011000:            cls = C_MUL;
                    6'b000000:            cls = C_NOP;
                    default:              cls = C_BAD;
                endcase
            end
            6'b001000: cls = C_ALU;
            6'b011100: cls = (bus.FUNCT == 6'b000010) ? C_MUL : C_BAD;
            default:   cls = C_BAD;
        endcase
    end

    // Next state plus the transition pulses (IR_LD, PC_INC, MUL_START),
    // which must coincide with the cycle that makes the transition.
    always_comb begin
        state_d   = state_q;
        mw_cnt_d  = mw_cnt_q;
        ir_ld     = 1'b0;
        mul_start = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_IDLE: if (bus.START && !bus.STOP) state_d = S_FETCH;
            S_FETCH: begin
                if (bus.MEM_READY) begin
                    ir_ld   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (cls)
                    C_ALU: state_d = S_EXEC;
                    C_MUL: begin
                        mul_start = 1'b1;
                        mw_cnt_d  = '0;
                        state_d   = S_MUL_WAIT;
                    end
                    C_NOP:   retire  = 1'b1;
                    default: state_d = S_TRAP;
                endcase
            end
            S_EXEC, S_WB: retire = 1'b1;
            S_MUL_WAIT: begin
                if (mw_cnt_q != MW_MAX) mw_cnt_d = mw_cnt_q + MW_W'(1);
                // A result arriving on the timeout cycle still completes.
                if (bus.MUL_DONE)                          state_d = S_WB;
                else if (mw_cnt_d == MW_W'(MUL_TIMEOUT))   state_d = S_TRAP;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
        // Instruction boundary: STOP diverts to IDLE after retirement.
        if (retire) state_d = bus.STOP ? S_IDLE : S_FETCH;
        pc_inc = retire;
    end

    // Level outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            mw_cnt_q    <= '0;
            instr_cnt_q <= '0;
            mem_rd_q    <= 1'b0;
            hab_q       <= 1'b0;
            busy_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mw_cnt_q  <= mw_cnt_d;
            if (retire) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
            mem_rd_q  <= (state_d == S_FETCH);
            hab_q     <= (state_d == S_EXEC) || (state_d == S_WB);
            busy_q    <= (state_d != S_IDLE) && (state_d != S_TRAP);
            illegal_q <= (state_d == S_TRAP);
        end
    end

    assign bus.MEM_RD    = mem_rd_q;
    assign bus.IR_LD     = ir_ld;
    assign bus.PC_INC    = pc_inc;
    assign bus.HAB       = hab_q;
    assign bus.MUL_START = mul_start;
    assign bus.BUSY      = busy_q;
    assign bus.ILLEGAL   = illegal_q;
    assign bus.INSTR_CNT = instr_cnt_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios with literal expectations plus
// an instruction-level model compared against every output each cycle.
module tb_cpu_sequencer;
    localparam int TB_CNT_W = 4;   // narrow counter so wrap is reachable
    localparam int TMO      = 15;

    localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_HAB = 3, P_MULW = 4, P_TRAP = 5;
    localparam int K_BAD = 0, K_ALU = 1, K_MUL = 2, K_NOP = 3;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    cpu_sequencer_if #(.CNT_W(TB_CNT_W)) bus();

    cpu_sequencer #(.MUL_TIMEOUT(TMO), .CNT_W(TB_CNT_W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        casez ({op, fn})
            12'b000000_100000, 12'b000000_100010, 12'b001000_??????: return K_ALU;
            12'b000000_011000, 12'b011100_000010:                    return K_MUL;
            12'b000000_000000:                                       return K_NOP;
            default:                                                 return K_BAD;
        endcase
    endfunction

    // Instruction-level model: EXEC and WB collapse into one "control
    // visible" phase; the multiply wait is a plain elapsed-cycle count.
    int m_pos = P_IDLE;
    int m_waited = 0;
    int m_cnt = 0;

    always @(posedge CLK) begin
        int p, w, c;
        bit ret;
        p = m_pos; w = m_waited; c = m_cnt; ret = 1'b0;
        if (!RST_N) begin
            p = P_IDLE; w = 0; c = 0;
        end else begin
            case (m_pos)
                P_IDLE:  if (bus.START && !bus.STOP) p = P_FETCH;
                P_FETCH: if (bus.MEM_READY) p = P_DEC;
                P_DEC: begin
                    case (classify(bus.OP_CODE, bus.FUNCT))
                        K_ALU:   p = P_HAB;
                        K_MUL:   begin p = P_MULW; w = 0; end
                        K_NOP:   ret = 1'b1;
                        default: p = P_TRAP;
                    endcase
                end
                P_HAB: ret = 1'b1;
                P_MULW: begin
                    w = w + 1;
                    if (bus.MUL_DONE)  p = P_HAB;
                    else if (w == TMO) p = P_TRAP;
                end
                default: ;
            endcase
            if (ret) begin
                c = (c + 1) % (1 << TB_CNT_W);
                p = bus.STOP ? P_IDLE : P_FETCH;
            end
        end
        m_pos    <= p;
        m_waited <= w;
        m_cnt    <= c;
    end

    always @(negedge CLK) begin
        int k;
        if (chk_en) begin
            k = classify(bus.OP_CODE, bus.FUNCT);
            chk("m_MEM_RD",    32'(bus.MEM_RD),    32'(m_pos == P_FETCH));
            chk("m_IR_LD",     32'(bus.IR_LD),     32'(m_pos == P_FETCH && bus.MEM_READY));
            chk("m_HAB",       32'(bus.HAB),       32'(m_pos == P_HAB));
            chk("m_PC_INC",    32'(bus.PC_INC),    32'(m_pos == P_HAB || (m_pos == P_DEC && k == K_NOP)));
            chk("m_MUL_START", 32'(bus.MUL_START), 32'(m_pos == P_DEC && k == K_MUL));
            chk("m_BUSY",      32'(bus.BUSY),      32'(m_pos != P_IDLE && m_pos != P_TRAP));
            chk("m_ILLEGAL",   32'(bus.ILLEGAL),   32'(m_pos == P_TRAP));
            chk("m_INSTR_CNT", 32'(bus.INSTR_CNT), 32'(m_cnt));
        end
    end

    task automatic step(); @(posedge CLK); #1; endtask
    task automatic samp(); @(negedge CLK); endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_BUSY"},    32'(bus.BUSY),      0);
        chk({tag, "_MEM_RD"},  32'(bus.MEM_RD),    0);
        chk({tag, "_HAB"},     32'(bus.HAB),       0);
        chk({tag, "_ILLEGAL"}, 32'(bus.ILLEGAL),   0);
        chk({tag, "_PC_INC"},  32'(bus.PC_INC),    0);
        chk({tag, "_CNT"},     32'(bus.INSTR_CNT), 0);
    endtask

    task automatic do_reset(input string tag);
        step(); RST_N = 1'b0; bus.START = 0; bus.STOP = 0; bus.MEM_READY = 0; bus.MUL_DONE = 0;
        samp();
        step(); samp();
        chk_zero(tag);
    endtask

    // IDLE -> FETCH with memory not yet ready; returns in the first FETCH cycle.
    task automatic start_seq();
        step(); RST_N = 1'b1; bus.START = 1; bus.STOP = 0; bus.MEM_READY = 0;
        samp();
        step(); bus.START = 0;
        samp(); chk("start_MEM_RD", 32'(bus.MEM_RD), 1);
    endtask

    // From a FETCH cycle: deliver the instruction, return in its DECODE cycle.
    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
        step(); bus.OP_CODE = op; bus.FUNCT = fn; bus.MEM_READY = 1;
        samp(); chk("fd_IR_LD", 32'(bus.IR_LD), 1);
        step(); bus.MEM_READY = 0;
        samp();
    endtask

    // From the multiply DECODE cycle: MUL_DONE in wait cycle n.
    task automatic do_mul(input int n);
        chk("mul_START", 32'(bus.MUL_START), 1);
        for (int i = 1; i <= n; i++) begin
            step(); bus.MUL_DONE = (i == n);
            samp(); chk("mulw_HAB", 32'(bus.HAB), 0);
        end
        step(); bus.MUL_DONE = 0;
        samp();
        chk("wb_HAB", 32'(bus.HAB), 1);
        chk("wb_PC_INC", 32'(bus.PC_INC), 1);
        step(); samp();
        chk("post_wb_HAB", 32'(bus.HAB), 0);
    endtask

    initial begin
        bus.START = 0; bus.STOP = 0; bus.MEM_READY = 0; bus.MUL_DONE = 0;
        bus.OP_CODE = 6'b0; bus.FUNCT = 6'b0;
        step(); chk_en = 1'b1;
        do_reset("rst0");

        // ADD with memory ready on the first FETCH cycle.
        step(); RST_N = 1; bus.START = 1; bus.MEM_READY = 1; bus.OP_CODE = 6'b000000; bus.FUNCT = 6'b100000;
        samp(); chk("add_c0_BUSY", 32'(bus.BUSY), 0);
        step(); bus.START = 0;
        samp(); chk("add_c1_IR_LD", 32'(bus.IR_LD), 1); chk("add_c1_HAB", 32'(bus.HAB), 0);
        step(); bus.MEM_READY = 0;
        samp(); chk("add_c2_HAB", 32'(bus.HAB), 0);
        step(); samp(); chk("add_c3_HAB", 32'(bus.HAB), 1); chk("add_c3_PC_INC", 32'(bus.PC_INC), 1);
        step(); samp(); chk("add_c4_HAB", 32'(bus.HAB), 0); chk("add_cnt", 32'(bus.INSTR_CNT), 1);

        // Memory stall, with a spurious MUL_DONE thrown in.
        for (int i = 0; i < 4; i++) begin
            step(); bus.MUL_DONE = (i == 1);
            samp(); chk("stall_MEM_RD", 32'(bus.MEM_RD), 1); chk("stall_IR_LD", 32'(bus.IR_LD), 0);
        end
        bus.MUL_DONE = 0;

        fetch_decode(6'b011100, 6'b000010); do_mul(5);
        chk("mul_cnt", 32'(bus.INSTR_CNT), 2);
        fetch_decode(6'b000000, 6'b011000); do_mul(5);
        chk("mult_cnt", 32'(bus.INSTR_CNT), 3);
        fetch_decode(6'b000000, 6'b011000); do_mul(TMO);    // done on the timeout cycle
        chk("mult_edge_cnt", 32'(bus.INSTR_CNT), 4);
        fetch_decode(6'b000000, 6'b100010);
        step(); samp(); chk("sub_HAB", 32'(bus.HAB), 1);

        // NOP stream through the counter wrap: 5 + 12 = 17 -> 1.
        for (int i = 0; i < 12; i++) begin
            fetch_decode(6'b000000, 6'b000000);
            chk("nop_PC_INC", 32'(bus.PC_INC), 1); chk("nop_HAB", 32'(bus.HAB), 0);
        end
        step(); samp(); chk("wrap_cnt", 32'(bus.INSTR_CNT), 1);

        // Multiplier timeout.
        fetch_decode(6'b000000, 6'b011000);
        chk("tmo_MUL_START", 32'(bus.MUL_START), 1);
        for (int i = 0; i < TMO; i++) begin
            step(); samp(); chk("tmo_wait_ILLEGAL", 32'(bus.ILLEGAL), 0);
        end
        step(); samp();
        chk("tmo_ILLEGAL", 32'(bus.ILLEGAL), 1); chk("tmo_BUSY", 32'(bus.BUSY), 0);
        for (int i = 0; i < 3; i++) begin
            step(); bus.START = 1;
            samp(); chk("trap_hold", 32'(bus.ILLEGAL), 1); chk("trap_MEM_RD", 32'(bus.MEM_RD), 0);
        end
        do_reset("rst_trap");

        // NOP then illegal encoding.
        start_seq();
        fetch_decode(6'b000000, 6'b000000);
        chk("nop2_PC_INC", 32'(bus.PC_INC), 1); chk("nop2_HAB", 32'(bus.HAB), 0);
        step(); samp(); chk("nop2_cnt", 32'(bus.INSTR_CNT), 1);
        fetch_decode(6'b000000, 6'b111111);
        chk("ill_PC_INC", 32'(bus.PC_INC), 0); chk("ill_HAB", 32'(bus.HAB), 0);
        step(); samp(); chk("ill_ILLEGAL", 32'(bus.ILLEGAL), 1); chk("ill_BUSY", 32'(bus.BUSY), 0);
        do_reset("rst_ill");

        // STOP during EXEC of ADDI, then START+STOP in IDLE.
        start_seq();
        fetch_decode(6'b001000, 6'b010101);
        step(); bus.STOP = 1;
        samp(); chk("stop_HAB", 32'(bus.HAB), 1); chk("stop_PC_INC", 32'(bus.PC_INC), 1);
        step(); bus.STOP = 0;
        samp(); chk("stop_BUSY", 32'(bus.BUSY), 0); chk("stop_cnt", 32'(bus.INSTR_CNT), 1);
        step(); bus.START = 1; bus.STOP = 1;
        samp();
        step(); samp(); chk("ss_BUSY", 32'(bus.BUSY), 0); chk("ss_MEM_RD", 32'(bus.MEM_RD), 0);
        step(); bus.START = 0; bus.STOP = 0;
        samp();

        // Reset in the middle of a multiply wait.
        start_seq();
        fetch_decode(6'b011100, 6'b000010);
        for (int i = 0; i < 3; i++) begin step(); samp(); end
        step(); RST_N = 0;
        samp(); chk("mw_BUSY", 32'(bus.BUSY), 1);
        step(); RST_N = 1;
        samp(); chk_zero("rst_mulw");

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
